// File: rtl/key_scan_pkg.sv
// Shared types and defaults for the key scan / debounce block.
package key_scan_pkg;

    localparam int unsigned DELAY_TOP_20MS_50M = 1_000_000;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw active-low key pins; resets to released (all 1s).
module key_sync #(
    parameter int unsigned KEY_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] key_n_i,
    output logic [KEY_WIDTH-1:0] key_n_o
);

    logic [KEY_WIDTH-1:0] meta_q;
    logic [KEY_WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
        end
    end

    assign key_n_o = sync_q;

endmodule

// File: rtl/key_scan_debounce.sv
// Debounces KEY_WIDTH active-low keys and emits one key_flag pulse per confirmed press,
// with the pressed-key bitmap held on key_value until the next press.
module key_scan_debounce
    import key_scan_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 4,
    parameter int unsigned DELAY_TOP = DELAY_TOP_20MS_50M
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] key_n,
    output logic                 key_flag,
    output logic [KEY_WIDTH-1:0] key_value,
    output logic                 key_busy
);

    localparam int unsigned          CNT_W    = $clog2(DELAY_TOP);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DELAY_TOP - 1);

    logic [KEY_WIDTH-1:0] key_n_sync;
    logic [KEY_WIDTH-1:0] pressed;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [KEY_WIDTH-1:0] snap_q, snap_d;
    logic                 flag_q, flag_d;
    logic [KEY_WIDTH-1:0] value_q, value_d;
    logic                 busy_q, busy_d;

    key_sync #(
        .KEY_WIDTH(KEY_WIDTH)
    ) u_key_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n_i(key_n),
        .key_n_o(key_n_sync)
    );

    assign pressed = ~key_n_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            flag_q  <= 1'b0;
            value_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            flag_q  <= flag_d;
            value_q <= value_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        flag_d  = 1'b0;
        value_d = value_q;
        cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (pressed != '0) begin
                    snap_d  = pressed;
                    cnt_d   = '0;
                    state_d = S_PRESS_DB;
                end
            end
            S_PRESS_DB: begin
                if (pressed == '0) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (pressed != snap_q) begin
                    // A changed bitmap restarts the window so combos report as one event.
                    snap_d = pressed;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    flag_d  = 1'b1;
                    value_d = snap_q;
                    cnt_d   = '0;
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HELD: begin
                if (pressed == '0) begin
                    cnt_d   = '0;
                    state_d = S_REL_DB;
                end
            end
            S_REL_DB: begin
                if (pressed != '0) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign key_flag  = flag_q;
    assign key_value = value_q;
    assign key_busy  = busy_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with DELAY_TOP=16: flag lands 18 edges after the key settles.
module tb_key_scan_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic       key_flag;
    logic [3:0] key_value;
    logic       key_busy;

    logic [3:0] cur_val;
    int         n_vec;
    int         n_bad;

    key_scan_debounce #(
        .KEY_WIDTH(4),
        .DELAY_TOP(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .key_flag (key_flag),
        .key_value(key_value),
        .key_busy (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // i=0 is the first edge sampling the current inputs; at<0 means no flag expected.
    task automatic watch(input string tag, input int n, input int at, input logic [3:0] val);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, " flag"}, 32'(key_flag), 32'(i == at));
            if (i == at) cur_val = val;
            chk({tag, " value"}, 32'(key_value), 32'(cur_val));
        end
    endtask

    task automatic release_all(input string tag);
        key_n = 4'b1111;
        watch(tag, 25, -1, 4'b0000);
        chk({tag, " busy idle"}, 32'(key_busy), 32'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        cur_val = 4'b0000;
        rst_n   = 1'b0;
        key_n   = 4'b0000;

        // 1: reset with all keys down, then re-detected as one press
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1 rst flag", 32'(key_flag), 32'd0);
            chk("t1 rst value", 32'(key_value), 32'd0);
            chk("t1 rst busy", 32'(key_busy), 32'd0);
        end
        rst_n = 1'b1;
        watch("t1 press", 30, 18, 4'b1111);
        release_all("t1 release");

        // 2: clean single press
        key_n = 4'b1110;
        watch("t2 press", 40, 18, 4'b0001);
        chk("t2 busy held", 32'(key_busy), 32'd1);
        release_all("t2 release");

        // 3: press bounce shorter than the window
        for (int b = 0; b < 10; b++) begin
            key_n = (b % 2 == 0) ? 4'b1110 : 4'b1111;
            watch("t3 bounce", 3, -1, 4'b0000);
        end
        key_n = 4'b1111;
        watch("t3 settle", 20, -1, 4'b0000);
        chk("t3 busy idle", 32'(key_busy), 32'd0);

        // 4: second key joins 5 edges in, window restarts
        key_n = 4'b1110;
        watch("t4 first", 5, -1, 4'b0000);
        key_n = 4'b1100;
        watch("t4 combo", 30, 18, 4'b0011);
        release_all("t4 release");

        // 5: release bounce, then a fresh press
        key_n = 4'b1011;
        watch("t5 press", 25, 18, 4'b0100);
        for (int b = 0; b < 4; b++) begin
            key_n = 4'b1111;
            watch("t5 rel bounce", 5, -1, 4'b0000);
            key_n = 4'b1011;
            watch("t5 rel bounce", 2, -1, 4'b0000);
        end
        release_all("t5 release");
        key_n = 4'b0111;
        watch("t5 repress", 25, 18, 4'b1000);
        release_all("t5 release2");

        // 6: reset at cnt=10 inside the press window
        key_n = 4'b1110;
        watch("t6 window", 13, -1, 4'b0000);
        rst_n = 1'b0;
        step();
        cur_val = 4'b0000;
        chk("t6 rst flag", 32'(key_flag), 32'd0);
        chk("t6 rst value", 32'(key_value), 32'd0);
        chk("t6 rst busy", 32'(key_busy), 32'd0);
        rst_n = 1'b1;
        watch("t6 redetect", 30, 18, 4'b0001);
        release_all("t6 release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
